// File: rtl/pin_entry_ctrl.sv
// PIN entry FSM: collects PIN_LEN hex digits, checks them against PIN_KEY, and counts failures into a timed lockout.
// Status is registered from the next state, so it lands 2 cycles after the final press; there is no backpressure.
module pin_entry_ctrl #(
  parameter int                   PIN_LEN        = 4,
  parameter logic [4*PIN_LEN-1:0] PIN_KEY        = 16'h2718,
  parameter int                   MAX_FAILS      = 3,
  parameter logic [23:0]          FAIL_CYCLES    = 24'd5_000_000,
  parameter logic [27:0]          LOCKOUT_CYCLES = 28'd100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] enc,
  input  logic [2:0] pb_press_type,
  output logic [3:0] display_value,
  output logic [2:0] digit_idx,
  output logic       unlocked,
  output logic       fail_flag,
  output logic       locked_out,
  output logic [2:0] fail_cnt
);

  localparam logic [2:0]  PB_SHORT = 3'b001;
  localparam logic [2:0]  PB_LONG  = 3'b010;
  localparam logic [2:0]  LAST_IDX = 3'(PIN_LEN - 1);
  localparam logic [2:0]  MAX_F    = 3'(MAX_FAILS);
  localparam int unsigned FAIL_N   = 32'(FAIL_CYCLES);
  localparam int unsigned LOCK_N   = 32'(LOCKOUT_CYCLES);
  localparam int unsigned T_MAX    = (FAIL_N > LOCK_N) ? FAIL_N : LOCK_N;
  localparam int          TW       = $clog2(T_MAX + 1);
  // The timer is loaded with N-1 and leaves its state on the cycle it reads 0, so the state lasts exactly N cycles.
  localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_N - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_N - 1);

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_FAIL     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  state_t               state;
  logic [4*PIN_LEN-1:0] pin_buf;
  logic [TW-1:0]        timer;
  logic                 last_fail;

  assign last_fail = ({1'b0, fail_cnt} + 4'd1) >= {1'b0, MAX_F};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ENTRY;
      pin_buf       <= '0;
      timer         <= '0;
      digit_idx     <= 3'd0;
      fail_cnt      <= 3'd0;
      unlocked      <= 1'b0;
      fail_flag     <= 1'b0;
      locked_out    <= 1'b0;
      display_value <= 4'h0;
    end else begin
      case (state)
        ST_ENTRY: begin
          display_value <= enc;
          if (pb_press_type == PB_SHORT) begin
            // The first digit entered is kept in the most-significant nibble.
            for (int i = 0; i < PIN_LEN; i++) begin
              if (digit_idx == 3'(i)) pin_buf[4*(PIN_LEN-1-i) +: 4] <= enc;
            end
            if (digit_idx == LAST_IDX) begin
              digit_idx <= 3'd0;
              state     <= ST_CHECK;
            end else begin
              digit_idx <= digit_idx + 3'd1;
            end
          end else if (pb_press_type == PB_LONG) begin
            pin_buf   <= '0;
            digit_idx <= 3'd0;
          end
        end
        ST_CHECK: begin
          pin_buf <= '0;
          if (pin_buf == PIN_KEY) begin
            state         <= ST_UNLOCKED;
            fail_cnt      <= 3'd0;
            unlocked      <= 1'b1;
            display_value <= 4'hA;
          end else if (last_fail) begin
            state         <= ST_LOCKOUT;
            fail_cnt      <= MAX_F;
            locked_out    <= 1'b1;
            display_value <= 4'hE;
            timer         <= LOCK_LOAD;
          end else begin
            state         <= ST_FAIL;
            fail_cnt      <= fail_cnt + 3'd1;
            fail_flag     <= 1'b1;
            display_value <= 4'hF;
            timer         <= FAIL_LOAD;
          end
        end
        ST_UNLOCKED: begin
          if (pb_press_type == PB_LONG) begin
            state         <= ST_ENTRY;
            unlocked      <= 1'b0;
            display_value <= enc;
          end
        end
        ST_FAIL: begin
          if (timer == '0) begin
            state         <= ST_ENTRY;
            fail_flag     <= 1'b0;
            display_value <= enc;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (timer == '0) begin
            state         <= ST_ENTRY;
            locked_out    <= 1'b0;
            fail_cnt      <= 3'd0;
            display_value <= enc;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state         <= ST_ENTRY;
          pin_buf       <= '0;
          timer         <= '0;
          digit_idx     <= 3'd0;
          fail_cnt      <= 3'd0;
          unlocked      <= 1'b0;
          fail_flag     <= 1'b0;
          locked_out    <= 1'b0;
          display_value <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
Passcode-entry controller for the csit_luks unlock flow. It sits downstream of the rotational encoder and upstream of the seven-segment driver. The rotational encoder supplies the selected digit and classified push-button events. This block collects a PIN digit by digit, compares it against a parameterised key, tracks failed attempts and enforces a lockout. It drives the digit and status shown on the display.

Parameters:
- PIN_LEN, 4, number of hex digits per PIN (2..8).
- PIN_KEY, 16'h2718, reference PIN, width 4*PIN_LEN; the most-significant nibble is the first digit entered.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..7).
- FAIL_CYCLES, 24'd5_000_000, number of cycles the fail indication is held.
- LOCKOUT_CYCLES, 28'd100_000_000, lockout duration in cycles.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enc, input, 4, current encoder digit (0..15).
- pb_press_type, input, 3, push-button event, valid for one cycle: 3'b000 none, 3'b001 short press, 3'b010 long press, all other codes ignored.
- display_value, output, 4, nibble forwarded to the seven-segment display_value input.
- digit_idx, output, 3, index of the digit currently being entered (0..PIN_LEN-1).
- unlocked, output, 1, high while in UNLOCKED.
- fail_flag, output, 1, high while in FAIL.
- locked_out, output, 1, high while in LOCKOUT.
- fail_cnt, output, 3, consecutive failed attempts.

Behaviour:
- The block uses one clock domain. All state and outputs are registered.
- Reset (rst=1 at a clk edge) is synchronous. After reset:
  - state=ENTRY, digit_idx=0, fail_cnt=0
  - the entry buffer is cleared
  - unlocked=fail_flag=locked_out=0
  - display_value=enc as registered (4'h0 on the reset cycle)
- Reset asserted in any state, including mid-entry or mid-lockout, aborts the operation and applies the values above on the next edge.
- States are ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT.
- ENTRY:
  - display_value <= enc every cycle.
  - Short press: buf[digit_idx] <= enc.
    - If digit_idx < PIN_LEN-1, digit_idx increments.
    - Otherwise the last digit is stored, digit_idx returns to 0 and the state goes to CHECK.
  - Long press: the buffer is cleared, digit_idx=0 and the state stays in ENTRY (cancel entry).
- CHECK lasts exactly one cycle. Press events received in CHECK are dropped.
  - If the buffer equals PIN_KEY: state goes to UNLOCKED and fail_cnt=0.
  - Else, if fail_cnt+1 == MAX_FAILS: fail_cnt increments and the state goes to LOCKOUT.
  - Else: fail_cnt increments and the state goes to FAIL.
  - The buffer is cleared on exit from CHECK in all cases.
- UNLOCKED:
  - unlocked=1, display_value=4'hA.
  - Long press: state goes to ENTRY (relock). fail_cnt stays 0.
  - Short press is ignored.
- FAIL:
  - fail_flag=1, display_value=4'hF.
  - The timer counts FAIL_CYCLES cycles, then the state goes to ENTRY.
  - All presses are ignored.
- LOCKOUT:
  - locked_out=1, display_value=4'hE.
  - The timer counts LOCKOUT_CYCLES cycles, then the state goes to ENTRY with fail_cnt=0.
  - All presses are ignored.
- Timing and latency:
  - The state changes on the edge that samples the press.
  - Status outputs are registered from the next state, so they are valid in the first cycle of the new state.
  - Latency from the final short press to unlocked, fail_flag or locked_out is 2 cycles.
- A single shared timer, sized for the larger of FAIL_CYCLES and LOCKOUT_CYCLES, is loaded on entry to FAIL or LOCKOUT and counts down to 0. Timer wrap-around is not permitted.
- Changing enc without a press never alters stored digits.
- fail_cnt saturates at MAX_FAILS and never wraps.
- Illegal state encodings recover to ENTRY with the outputs cleared.

Test Plan:
Simulation uses PIN_KEY=16'h2718, MAX_FAILS=3, FAIL_CYCLES=4 and LOCKOUT_CYCLES=16.
1. Correct PIN: short presses with enc=2,7,1,8. Required: digit_idx steps 1,2,3,0; unlocked=1 two cycles after the 4th press; display_value=4'hA; fail_cnt=0.
2. Wrong PIN: enter 2,7,1,9. Required: fail_flag=1 for exactly 4 cycles; display_value=4'hF; fail_cnt=1; then ENTRY with digit_idx=0.
3. Lockout and recovery:
   - Three wrong PINs in a row. Required: locked_out=1 with display_value=4'hE for 16 cycles, with presses ignored; then ENTRY with fail_cnt=0.
   - Then enter the correct PIN. Required: unlocked=1.
4. Cancel: enter 2,7, long press, then 2,7,1,8. Required: unlocked=1, which proves the buffer was cleared. Also rotate enc between presses and check that display_value tracks enc with 1-cycle latency.
5. Relock and ignored presses:
   - While UNLOCKED, short press. Required: still unlocked.
   - Long press. Required: ENTRY, unlocked=0.
   - Press codes 3'b011 and 3'b111 in ENTRY. Required: digit_idx unchanged.
6. Reset mid-operation:
   - Assert rst for 1 cycle after 3 digits. Required: digit_idx=0 and all flags 0 on the next edge.
   - Assert rst during LOCKOUT. Required: immediate ENTRY with fail_cnt=0.
